// File: rtl/vram_sram_responder_pkg.sv
// Shared VRAM definitions: SRAM access timing defaults, VRAM geometry,
// and the responder state encoding.
package vram_sram_responder_pkg;

    localparam int SRAM_READ_CYCLES  = 2;
    localparam int SRAM_WRITE_CYCLES = 2;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int H_SIZE    = 320;
    localparam int V_SIZE    = 240;

    typedef enum logic [5:0] {
        S_INIT  = 6'b000001,
        S_IDLE  = 6'b000010,
        S_READ  = 6'b000100,
        S_RDV   = 6'b001000,
        S_WRITE = 6'b010000,
        S_WREC  = 6'b100000
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vram_sram_responder.sv
// Avalon-MM responder driving the asynchronous 16-bit VRAM SRAM.
// One command in flight; strobe widths set by READ_CYCLES / WRITE_CYCLES.
module vram_sram_responder
    import vram_sram_responder_pkg::*;
#(
    parameter int AVN_AW       = 19,
    parameter int AVN_DW       = 16,
    parameter int READ_CYCLES  = SRAM_READ_CYCLES,
    parameter int WRITE_CYCLES = SRAM_WRITE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AVN_AW-1:0]     vram_avn_address,
    input  logic                  vram_avn_read,
    input  logic                  vram_avn_write,
    input  logic [AVN_DW-1:0]     vram_avn_writedata,
    input  logic [AVN_DW/8-1:0]   vram_avn_byteenable,
    output logic [AVN_DW-1:0]     vram_avn_readdata,
    output logic                  vram_avn_waitrequest,
    output logic                  vram_avn_readdatavalid,
    output logic [AVN_AW-1:0]     sram_addr,
    inout  wire  [AVN_DW-1:0]     sram_dq,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_lb_n,
    output logic                  sram_ub_n
);

    localparam int I_IDLE  = 1;
    localparam int I_READ  = 2;
    localparam int I_RDV   = 3;
    localparam int I_WRITE = 4;
    localparam int I_WREC  = 5;
    localparam int I_INIT  = 0;

    localparam int CW = $clog2(max2(READ_CYCLES, WRITE_CYCLES) + 1);
    localparam logic [CW-1:0] R_LAST = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WRITE_CYCLES - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AVN_DW-1:0] dq_out;
    logic              dq_oe;

    assign sram_dq = dq_oe ? dq_out : {AVN_DW{1'bz}};

    assign vram_avn_waitrequest   = ~(state[I_IDLE] | state[I_RDV]);
    assign vram_avn_readdatavalid = state[I_RDV];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_INIT;
            cnt               <= '0;
            dq_out            <= '0;
            dq_oe             <= 1'b0;
            vram_avn_readdata <= '0;
            sram_addr         <= '0;
            sram_ce_n         <= 1'b1;
            sram_oe_n         <= 1'b1;
            sram_we_n         <= 1'b1;
            sram_lb_n         <= 1'b1;
            sram_ub_n         <= 1'b1;
        end else begin
            unique case (1'b1)
                state[I_INIT]: state <= S_IDLE;
                state[I_IDLE], state[I_RDV]: begin
                    // A simultaneous read+write resolves to the read.
                    if (vram_avn_read || vram_avn_write) begin
                        sram_addr <= vram_avn_address;
                        dq_out    <= vram_avn_writedata;
                        cnt       <= '0;
                        sram_ce_n <= 1'b0;
                        if (vram_avn_read) begin
                            state     <= S_READ;
                            sram_oe_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                        end else begin
                            state     <= S_WRITE;
                            sram_we_n <= 1'b0;
                            sram_lb_n <= ~vram_avn_byteenable[0];
                            sram_ub_n <= ~vram_avn_byteenable[AVN_DW/8-1];
                            dq_oe     <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                state[I_READ]: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == R_LAST) begin
                        vram_avn_readdata <= sram_dq;
                        state             <= S_RDV;
                        sram_ce_n         <= 1'b1;
                        sram_oe_n         <= 1'b1;
                        sram_lb_n         <= 1'b1;
                        sram_ub_n         <= 1'b1;
                    end
                end
                state[I_WRITE]: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == W_LAST) begin
                        state     <= S_WREC;
                        sram_we_n <= 1'b1;
                    end
                end
                state[I_WREC]: begin
                    // Data was held one extra cycle past we_n rising.
                    state     <= S_IDLE;
                    sram_ce_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    dq_oe     <= 1'b0;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_sram_responder.sv
// Directed bench for vram_sram_responder with a behavioural async SRAM.
// Table of commands plus hand sequences for back-to-back and mid-write reset.
module tb_vram_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [18:0] address = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        rdv;
    logic [18:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];

    vram_sram_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .vram_avn_address(address),
        .vram_avn_read(rd),
        .vram_avn_write(wr),
        .vram_avn_writedata(wdata),
        .vram_avn_byteenable(be),
        .vram_avn_readdata(readdata),
        .vram_avn_waitrequest(waitrequest),
        .vram_avn_readdatavalid(rdv),
        .sram_addr(sram_addr),
        .sram_dq(sram_dq),
        .sram_ce_n(ce_n),
        .sram_oe_n(oe_n),
        .sram_we_n(we_n),
        .sram_lb_n(lb_n),
        .sram_ub_n(ub_n)
    );

    always #5 clk = ~clk;

    assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [18:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic issue(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        address = v.addr;
        rd = v.rd;
        wr = v.wr;
        wdata = v.wd;
        be = v.be;
        while (waitrequest && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'b0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (v.rd) begin
                if (k <= 2) begin
                    chk("rd_oe_n", {31'b0, oe_n}, 32'd0);
                    chk("rd_ce_n", {31'b0, ce_n}, 32'd0);
                    chk("rd_we_n", {31'b0, we_n}, 32'd1);
                    chk("rd_addr", {13'b0, sram_addr}, {13'b0, v.addr});
                    chk("rd_rdv_early", {31'b0, rdv}, 32'd0);
                end else if (k == 3) begin
                    chk("rd_rdv", {31'b0, rdv}, 32'd1);
                    chk("rd_data", {16'b0, readdata}, {16'b0, v.exp});
                    chk("rd_oe_off", {31'b0, oe_n}, 32'd1);
                    chk("rd_we_off", {31'b0, we_n}, 32'd1);
                end else begin
                    chk("rd_rdv_pulse", {31'b0, rdv}, 32'd0);
                    chk("rd_idle_wait", {31'b0, waitrequest}, 32'd0);
                end
            end else begin
                if (k <= 2) begin
                    chk("wr_we_n", {31'b0, we_n}, 32'd0);
                    chk("wr_oe_n", {31'b0, oe_n}, 32'd1);
                    chk("wr_lb_n", {31'b0, lb_n}, {31'b0, ~v.be[0]});
                    chk("wr_ub_n", {31'b0, ub_n}, {31'b0, ~v.be[1]});
                    chk("wr_dq", {16'b0, sram_dq}, {16'b0, v.wd});
                    chk("wr_addr", {13'b0, sram_addr}, {13'b0, v.addr});
                    chk("wr_wait", {31'b0, waitrequest}, 32'd1);
                end else if (k == 3) begin
                    chk("wrec_we_n", {31'b0, we_n}, 32'd1);
                    chk("wrec_ce_n", {31'b0, ce_n}, 32'd0);
                    chk("wrec_dq", {16'b0, sram_dq}, {16'b0, v.wd});
                    chk("wrec_wait", {31'b0, waitrequest}, 32'd1);
                end else begin
                    chk("wr_done_wait", {31'b0, waitrequest}, 32'd0);
                    chk("wr_done_ce_n", {31'b0, ce_n}, 32'd1);
                    chk("wr_dq_release", {31'b0, sram_dq !== v.wd}, 32'd1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h345] = 16'hBEEF;
        mem[10'h280] = 16'h1234;
        mem[10'h000] = 16'h1111;
        mem[10'h001] = 16'h2222;
        mem[10'h005] = 16'h5555;
        mem[10'h3FF] = 16'h7777;

        tbl[0] = '{1'b1, 1'b0, 19'h12345, 16'h0000, 2'b00, 16'hBEEF};
        tbl[1] = '{1'b0, 1'b1, 19'h00280, 16'hA55A, 2'b10, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 19'h00280, 16'h0000, 2'b00, 16'hA534};
        tbl[3] = '{1'b0, 1'b1, 19'h00280, 16'hFFFF, 2'b00, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 19'h00280, 16'h0000, 2'b00, 16'hA534};
        tbl[5] = '{1'b0, 1'b1, 19'h00005, 16'h00C3, 2'b01, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 19'h00005, 16'h0000, 2'b00, 16'h55C3};
        tbl[7] = '{1'b1, 1'b1, 19'h00005, 16'hDEAD, 2'b11, 16'h55C3};
        tbl[8] = '{1'b1, 1'b0, 19'h00005, 16'h0000, 2'b00, 16'h55C3};
        tbl[9] = '{1'b1, 1'b0, 19'h7FFFF, 16'h0000, 2'b00, 16'h7777};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wait", {31'b0, waitrequest}, 32'd1);
        chk("rst_rdv", {31'b0, rdv}, 32'd0);
        chk("rst_rdata", {16'b0, readdata}, 32'd0);
        chk("rst_strobes", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        chk("rst_addr", {13'b0, sram_addr}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("init_wait", {31'b0, waitrequest}, 32'd1);
        @(negedge clk);
        chk("idle_wait", {31'b0, waitrequest}, 32'd0);
        chk("idle_strobes", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back reads: second accepted in the first's valid cycle
        v = '{1'b1, 1'b0, 19'h00000, 16'h0000, 2'b00, 16'h1111};
        issue(v);
        @(negedge clk);
        address = 19'h00001;
        rd = 1'b1;
        chk("b2b_oe_n", {31'b0, oe_n}, 32'd0);
        @(negedge clk);
        chk("b2b_hold_wait", {31'b0, waitrequest}, 32'd1);
        @(negedge clk);
        chk("b2b_rdv0", {31'b0, rdv}, 32'd1);
        chk("b2b_data0", {16'b0, readdata}, 32'h1111);
        chk("b2b_accept", {31'b0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(negedge clk);
        chk("b2b_oe_n1", {31'b0, oe_n}, 32'd0);
        chk("b2b_addr1", {13'b0, sram_addr}, 32'd1);
        chk("b2b_rdv_gap", {31'b0, rdv}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_rdv1", {31'b0, rdv}, 32'd1);
        chk("b2b_data1", {16'b0, readdata}, 32'h2222);
        @(negedge clk);
        chk("b2b_rdv_end", {31'b0, rdv}, 32'd0);

        // Reset dropped in the middle of a write
        v = '{1'b0, 1'b1, 19'h00010, 16'h0F0F, 2'b11, 16'h0000};
        issue(v);
        @(negedge clk);
        chk("mid_we_n", {31'b0, we_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'b0, we_n}, 32'd1);
        chk("mid_rst_ce_n", {31'b0, ce_n}, 32'd1);
        chk("mid_rst_wait", {31'b0, waitrequest}, 32'd1);
        chk("mid_rst_dq", {31'b0, sram_dq !== 16'h0F0F}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wait", {31'b0, waitrequest}, 32'd0);
        run_vec(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
